// File: rtl/stream_fork_dyn_tracked.sv
// Handshake-only stream fork to a runtime-selected subset of outputs.
// Each selected output gets exactly one handshake per input transaction.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   inp_valid_i  upstream valid
//   inp_ready_o  upstream ready
//   sel_i        output select mask, bit i set = output i takes part
//   oup_valid_o  per-output valid
//   oup_ready_i  per-output ready
//
// Optional: define STREAM_FORK_DYN_TRACKED_SPILL_EN to put a 2-entry
// spill buffer (valid + captured sel) in front of the fork logic.
module stream_fork_dyn_tracked #(
    parameter int unsigned N_OUP = 32'd2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inp_valid_i,
    output logic             inp_ready_o,
    input  logic [N_OUP-1:0] sel_i,
    output logic [N_OUP-1:0] oup_valid_o,
    input  logic [N_OUP-1:0] oup_ready_i
);

    logic [N_OUP-1:0] sent_q;
    logic [N_OUP-1:0] done;
    logic             fork_valid;
    logic [N_OUP-1:0] fork_sel;
    logic             fork_ready;

    assign oup_valid_o = {N_OUP{fork_valid}} & fork_sel & ~sent_q;
    assign done        = ~fork_sel | sent_q | oup_ready_i;
    assign fork_ready  = fork_valid & (&done);

    // Completing the transaction wins over per-output updates so that
    // flags set by outputs finishing in that same cycle are not kept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sent_q <= '0;
        end else if (fork_ready) begin
            sent_q <= '0;
        end else begin
            sent_q <= sent_q | (oup_valid_o & oup_ready_i);
        end
    end

`ifdef STREAM_FORK_DYN_TRACKED_SPILL_EN
    logic [1:0]       vld_q;
    logic [N_OUP-1:0] sel_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       cnt_q;
    logic             push;
    logic             pop;

    // Ready depends only on occupancy, cutting the combinational path
    // from downstream ready back to the upstream.
    assign inp_ready_o = (cnt_q != 2'd2);
    assign push        = inp_valid_i & inp_ready_o;
    assign pop         = fork_ready;
    assign fork_valid  = vld_q[rd_ptr_q];
    assign fork_sel    = sel_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q    <= '0;
            sel_q[0] <= '0;
            sel_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (pop) begin
                vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= ~rd_ptr_q;
            end
            if (push) begin
                vld_q[wr_ptr_q] <= 1'b1;
                sel_q[wr_ptr_q] <= sel_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + 2'd1;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - 2'd1;
            end
        end
    end
`else
    assign fork_valid  = inp_valid_i;
    assign fork_sel    = sel_i;
    assign inp_ready_o = fork_ready;
`endif

endmodule

// File: tb/tb_stream_fork_dyn_tracked.sv
// Self-checking bench for stream_fork_dyn_tracked (default build).
// Directed steps followed by randomized traffic against a set model.
module tb_stream_fork_dyn_tracked;

    localparam int N = 3;

    logic         clk;
    logic         rst_n;
    logic         valid;
    logic         ready;
    logic [N-1:0] sel;
    logic [N-1:0] ovalid;
    logic [N-1:0] ordy;

    int total = 0;
    int bad   = 0;

    // Model: set of selected outputs already served in this transaction.
    logic [N-1:0] served;
    logic [N-1:0] exp_v;
    logic         exp_r;
    logic         hs_last;

    stream_fork_dyn_tracked #(.N_OUP(N)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .inp_valid_i (valid),
        .inp_ready_o (ready),
        .sel_i       (sel),
        .oup_valid_o (ovalid),
        .oup_ready_i (ordy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag);
        logic [N-1:0] remaining;
        remaining = valid ? (sel & ~served) : '0;
        exp_v = remaining;
        exp_r = valid && ((remaining & ~ordy) == '0);
        total++;
        assert (ovalid === exp_v) else begin
            bad++;
            $error("FAIL %s oup_valid got=%b exp=%b", tag, ovalid, exp_v);
        end
        total++;
        assert (ready === exp_r) else begin
            bad++;
            $error("FAIL %s inp_ready got=%b exp=%b", tag, ready, exp_r);
        end
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        check(tag);
        @(posedge clk);
        hs_last = valid && exp_r;
        if (hs_last) served = '0;
        else served = served | (exp_v & ordy);
        #1;
    endtask

    initial begin
        served  = '0;
        hs_last = 1'b1;
        rst_n   = 1'b0;
        valid   = 1'b0;
        sel     = '0;
        ordy    = '0;
        #12;
        check("reset_idle");
        valid = 1'b1;
        sel   = 3'b111;
        #1;
        check("reset_valid");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All selected ready together: one-cycle completion.
        sel  = 3'b111;
        ordy = 3'b111;
        cycle("all_ready");
        cycle("all_ready_again");

        // Partial completion over two cycles.
        ordy = 3'b101;
        cycle("partial_c1");
        ordy = 3'b010;
        cycle("partial_c2");
        ordy = 3'b000;
        cycle("after_partial");
        ordy = 3'b111;
        cycle("finish_new");

        // Empty selection consumed silently.
        sel  = 3'b000;
        ordy = 3'b000;
        cycle("sel_zero");

        // Single output waiting on its ready.
        sel  = 3'b100;
        ordy = 3'b011;
        cycle("single_wait");
        ordy = 3'b111;
        cycle("single_go");

        // Async reset in the middle of a partial transaction.
        sel  = 3'b111;
        ordy = 3'b101;
        cycle("pre_reset");
        ordy = 3'b000;
        #1;
        rst_n = 1'b0;
        #1;
        served = '0;
        check("async_reset");
        rst_n = 1'b1;
        cycle("post_reset");
        ordy = 3'b111;
        cycle("post_reset_done");

        valid = 1'b0;
        ordy  = 3'b000;
        cycle("idle");

        // Randomized traffic obeying the upstream protocol.
        hs_last = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (hs_last || !valid) begin
                valid = ($urandom_range(0, 3) != 0);
                sel   = N'($urandom);
            end
            ordy = N'($urandom);
            cycle("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
